// File: rtl/toaplan2_gfx_pkg.sv
// Shared types for the Toaplan2 graphics ROM arbiter.
// FSM states, requester indices and the round-robin pick helper.
package toaplan2_gfx_pkg;

  localparam int NREQ     = 4;
  localparam int REQ_OBJ  = 0;
  localparam int REQ_SCR0 = 1;
  localparam int REQ_SCR1 = 2;
  localparam int REQ_SCR2 = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_FILL
  } gfx_state_e;

  // First set miss bit after last, wrapping, ending on last itself.
  function automatic logic [1:0] rr_pick(
    input logic [1:0]      last,
    input logic [NREQ-1:0] miss
  );
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last + 2'(k);
      if (!found && miss[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/toaplan2_gfx_slot.sv
// One-entry cache for a single graphics requester.
// Holds the cached word, its address and a valid bit.
import toaplan2_gfx_pkg::*;

module toaplan2_gfx_slot #(
  parameter int AW = 21
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  input  logic          fill_i,
  input  logic [AW-1:0] fill_addr_i,
  input  logic [31:0]   fill_data_i,
  output logic          ok_o,
  output logic          miss_o,
  output logic [31:0]   dout_o
);

  logic [AW-1:0] la_q;
  logic [31:0]   ld_q;
  logic          v_q;
  logic          hit;

  assign hit    = v_q && (addr_i == la_q);
  assign ok_o   = cs_i & hit & ~flush_i;
  assign miss_o = cs_i & ~hit;
  assign dout_o = ld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      la_q <= '0;
      ld_q <= '0;
      v_q  <= 1'b0;
    end else begin
      if (fill_i) begin
        la_q <= fill_addr_i;
        ld_q <= fill_data_i;
        v_q  <= 1'b1;
      end
      // Flush beats a coincident fill.
      if (flush_i) v_q <= 1'b0;
    end
  end

endmodule

// File: rtl/toaplan2_gfx_arbiter.sv
// Round-robin SDRAM bank arbiter for the four Toaplan2 GFX requesters.
// Misses are refilled as two 16-bit reads into per-requester slots.
import toaplan2_gfx_pkg::*;

module toaplan2_gfx_arbiter #(
  parameter int          AW        = 21,
  parameter logic [21:0] BA_OFFSET = 22'h0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic [3:0]       REQ_CS,
  input  logic [4*AW-1:0]  REQ_ADDR,
  output logic [3:0]       REQ_OK,
  output logic [127:0]     REQ_DOUT,
  output logic [21:0]      BA_ADDR,
  output logic             BA_RD,
  input  logic             BA_ACK,
  input  logic             BA_DOK,
  input  logic             BA_RDY,
  input  logic [15:0]      DATA_READ
);

  gfx_state_e    state_q;
  logic [1:0]    sel_q;
  logic [1:0]    last_q;
  logic [AW-1:0] faddr_q;
  logic          rd_q;
  logic [21:0]   ba_q;
  logic [1:0]    wcnt_q;
  logic [31:0]   tmp_q;

  logic [AW-1:0]   addr_a [NREQ];
  logic [NREQ-1:0] miss;
  logic [1:0]      pick_d;
  logic [21:0]     ba_d;
  logic            fill;

  assign fill    = (state_q == ST_FILL);
  assign pick_d  = rr_pick(last_q, miss);
  assign ba_d    = BA_OFFSET + {21'(addr_a[pick_d]), 1'b0};
  assign BA_ADDR = ba_q;
  assign BA_RD   = rd_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign addr_a[i] = REQ_ADDR[i*AW +: AW];
    toaplan2_gfx_slot #(.AW(AW)) u_slot (
      .clk_i      (CLK),
      .rst_i      (RESET),
      .flush_i    (FLUSH),
      .cs_i       (REQ_CS[i]),
      .addr_i     (addr_a[i]),
      .fill_i     (fill && (sel_q == 2'(i))),
      .fill_addr_i(faddr_q),
      .fill_data_i(tmp_q),
      .ok_o       (REQ_OK[i]),
      .miss_o     (miss[i]),
      .dout_o     (REQ_DOUT[i*32 +: 32])
    );
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= 2'd3;
      faddr_q <= '0;
      rd_q    <= 1'b0;
      ba_q    <= '0;
      wcnt_q  <= '0;
      tmp_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|miss) begin
            sel_q   <= pick_d;
            last_q  <= pick_d;
            faddr_q <= addr_a[pick_d];
            ba_q    <= ba_d;
            rd_q    <= 1'b1;
            wcnt_q  <= '0;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (BA_ACK) begin
            rd_q    <= 1'b0;
            state_q <= ST_DATA;
            if (BA_DOK) begin
              tmp_q[15:0] <= DATA_READ;
              wcnt_q      <= 2'd1;
            end
          end
        end
        ST_DATA: begin
          if (BA_DOK) begin
            if (wcnt_q == 2'd0) begin
              tmp_q[15:0] <= DATA_READ;
              wcnt_q      <= 2'd1;
            end else if (wcnt_q == 2'd1) begin
              tmp_q[31:16] <= DATA_READ;
              wcnt_q       <= 2'd2;
            end
          end
          if (BA_RDY) state_q <= ST_FILL;
        end
        ST_FILL: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
